// File: rtl/lu_arbiter_pkg.sv
// Shared types and constants for the two-requester OR/NOR arbiter.
// Tie-break policy is chosen in lu_arbiter via LU_ARBITER_FIXED_PRIO_EN.
package lu_arbiter_pkg;

    localparam int LU_WIDTH_DEFAULT = 8;

    localparam logic OP_OR  = 1'b0;
    localparam logic OP_NOR = 1'b1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } lu_state_e;

endpackage

// File: rtl/lu_arbiter_core.sv
// Purely combinational WIDTH-wide OR / NOR unit; sel chooses the inversion.
module lu_or_nor_core
    import lu_arbiter_pkg::*;
#(
    parameter int WIDTH = LU_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] or_s;

    assign or_s = a | b;

    // Select plain or inverted OR result
    always_comb begin
        if (sel == OP_NOR) begin
            y = ~or_s;
        end else begin
            y = or_s;
        end
    end

endmodule

// File: rtl/lu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared OR/NOR unit.
// Define LU_ARBITER_FIXED_PRIO_EN to make requester 0 win every tie.
module lu_arbiter
    import lu_arbiter_pkg::*;
#(
    parameter int WIDTH = LU_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_0,
    input  logic             req_valid_1,
    output logic             req_ready_0,
    output logic             req_ready_1,
    input  logic [WIDTH-1:0] req_a_0,
    input  logic [WIDTH-1:0] req_b_0,
    input  logic [WIDTH-1:0] req_a_1,
    input  logic [WIDTH-1:0] req_b_1,
    input  logic             req_sel_0,
    input  logic             req_sel_1,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
    output logic [15:0]      op_count
);

    lu_state_e        state_r;
    lu_state_e        state_nxt_s;
    logic             last_grant_r;
    logic             grant_vld_s;
    logic             grant_id_s;
    logic [WIDTH-1:0] rsp_data_r;
    logic             rsp_id_r;
    logic [15:0]      op_count_r;
    logic [WIDTH-1:0] mux_a_s;
    logic [WIDTH-1:0] mux_b_s;
    logic             mux_sel_s;
    logic [WIDTH-1:0] core_y_s;

    // Arbitration and next-state; grants only in IDLE and never under reset
    always_comb begin
        state_nxt_s = state_r;
        grant_vld_s = 1'b0;
        grant_id_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (rst) begin
                    state_nxt_s = IDLE;
                end else if (req_valid_0 && req_valid_1) begin
                    grant_vld_s = 1'b1;
`ifdef LU_ARBITER_FIXED_PRIO_EN
                    grant_id_s  = 1'b0;
`else
                    grant_id_s  = ~last_grant_r;
`endif
                    state_nxt_s = BUSY;
                end else if (req_valid_0) begin
                    grant_vld_s = 1'b1;
                    grant_id_s  = 1'b0;
                    state_nxt_s = BUSY;
                end else if (req_valid_1) begin
                    grant_vld_s = 1'b1;
                    grant_id_s  = 1'b1;
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    assign req_ready_0 = grant_vld_s & ~grant_id_s;
    assign req_ready_1 = grant_vld_s &  grant_id_s;

    assign mux_a_s   = grant_id_s ? req_a_1   : req_a_0;
    assign mux_b_s   = grant_id_s ? req_b_1   : req_b_0;
    assign mux_sel_s = grant_id_s ? req_sel_1 : req_sel_0;

    lu_or_nor_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a   (mux_a_s),
        .b   (mux_b_s),
        .sel (mux_sel_s),
        .y   (core_y_s)
    );

    // State, captured result and completion counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            rsp_data_r   <= {WIDTH{1'b0}};
            rsp_id_r     <= 1'b0;
            op_count_r   <= 16'd0;
            last_grant_r <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            if (grant_vld_s) begin
                rsp_data_r   <= core_y_s;
                rsp_id_r     <= grant_id_s;
                last_grant_r <= grant_id_s;
            end
            if ((state_r == BUSY) && rsp_ready) begin
                op_count_r <= op_count_r + 16'd1;
            end
        end
    end

    assign rsp_valid = (state_r == BUSY);
    assign rsp_data  = rsp_data_r;
    assign rsp_id    = rsp_id_r;
    assign op_count  = op_count_r;

endmodule

// File: doc/lu_arbiter.md
LU_ARBITER -- requirements
Module: lu_arbiter

Interface
REQ-001 Parameter: WIDTH, 8, operand/result bit width (bitwise logic unit).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid_0, req_valid_1  input  1  requester i has an operation pending.
REQ-005 req_ready_0, req_ready_1  output  1  requester i's operation accepted this cycle.
REQ-006 req_a_0, req_b_0, req_a_1, req_b_1  input  WIDTH  operands per requester.
REQ-007 req_sel_0, req_sel_1  input  1  0 = OR, 1 = NOR.
REQ-008 rsp_valid  output  1  result held on rsp_data.
REQ-009 rsp_ready  input  1  consumer accepts result.
REQ-010 rsp_data  output  WIDTH  registered result.
REQ-011 rsp_id  output  1  index of the requester that owns rsp_data.
REQ-012 op_count  output  16  number of completed responses.

Function
REQ-013 FSM SHALL have two states: IDLE and BUSY.
REQ-014 IDLE: at most one req_ready_i SHALL be high, for the arbitration winner only, combinationally from req_valid_*.
REQ-015 BUSY: both req_ready_i SHALL be low.
REQ-016 Single valid requester SHALL win; if both valid, the winner SHALL be the requester other than last_grant (round-robin).
REQ-017 On handshake (req_valid_i & req_ready_i), next cycle: state=BUSY, rsp_data = sel ? ~(a|b) : (a|b) of the winner, rsp_id = i, last_grant = i.
REQ-018 Latency: rsp_valid SHALL rise exactly 1 cycle after the accepting edge.
REQ-019 rsp_valid SHALL be high iff state=BUSY; rsp_data/rsp_id SHALL be stable while BUSY.
REQ-020 BUSY with rsp_ready=1: return to IDLE next cycle and increment op_count; no new request is accepted in that same cycle (max throughput 1 op per 2 cycles).
REQ-021 BUSY with rsp_ready=0: remain in BUSY indefinitely, values held.
REQ-022 op_count SHALL wrap from 0xFFFF to 0x0000.
REQ-023 Requester inputs changing while not granted SHALL have no effect; requester SHALL hold valid until ready (no ready in IDLE without valid).

Reset
REQ-024 rst=1 at an edge SHALL force state=IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, op_count=0, last_grant=1 (requester 0 wins first tie).
REQ-025 rst during BUSY SHALL discard the pending result without incrementing op_count; req_ready_* SHALL be low while rst=1.

Configuration
REQ-026 Macro LU_ARBITER_FIXED_PRIO_EN: when defined, requester 0 SHALL always win ties (last_grant ignored); when undefined, round-robin per REQ-016.

Structure
REQ-027 Shared package SHALL hold state enum (IDLE, BUSY), op-select constants (OP_OR=0, OP_NOR=1) and default WIDTH.
REQ-028 Logic unit SHALL be a sub-module lu_or_nor_core (WIDTH-wide OR/NOR with select, purely combinational), instantiated once and fed through the grant mux.

Verification
REQ-029 Reset, then req_valid_0=1, a=0x0F, b=0x30, sel=0 -> req_ready_0 same cycle; next cycle rsp_valid=1, rsp_data=0x3F, rsp_id=0.
REQ-030 Same operands, sel=1, requester 1 only -> rsp_data=0xC0, rsp_id=1.
REQ-031 Both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; op_count=4 after four responses (with FIXED_PRIO_EN: always 0).
REQ-032 rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data, rsp_id constant, both req_ready low, op_count unchanged.
REQ-033 rst asserted in BUSY -> next cycle rsp_valid=0, op_count=0, requester 0 wins next tie.
REQ-034 op_count preloaded via 65535 completions -> next completion yields op_count=0x0000.
